// File: rtl/hazard_stall_unit.sv
// RAW stall detection for the 5-stage MIPS core: E/M/W scoreboard of destinations and Tnew vs decode Tuse.
// Optional STALL_CNT_EN macro adds a free-running count of stalled cycles on stall_cnt.
module hazard_stall_unit #(
   parameter int NREG  = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IR_D,
   output logic             stall,
   output logic             en_PC,
   output logic             en_D,
   output logic             clr_E,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   logic [5:0]      opcode, funct;
   logic [NREG-1:0] rs, rt, rd;
   logic            shamt_zero;

   logic            use_rs, use_rt;
   logic [1:0]      tuse_rs, tuse_rt;
   logic [NREG-1:0] dec_dst;
   logic [1:0]      dec_tnew;

   logic [NREG-1:0] e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
   logic [1:0]      e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;

   assign opcode     = IR_D[31:26];
   assign rs         = IR_D[25:21];
   assign rt         = IR_D[20:16];
   assign rd         = IR_D[15:11];
   assign shamt_zero = (IR_D[10:6] == 5'd0);
   assign funct      = IR_D[5:0];

   always_comb begin
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      tuse_rs  = 2'd0;
      tuse_rt  = 2'd0;
      dec_dst  = '0;
      dec_tnew = 2'd0;
      unique case (opcode)
         OP_RTYPE: begin
            // Non-zero shamt is not a supported encoding and decodes as nop.
            if (shamt_zero && (funct == FN_ADDU || funct == FN_SUBU)) begin
               use_rs   = 1'b1;
               use_rt   = 1'b1;
               tuse_rs  = 2'd1;
               tuse_rt  = 2'd1;
               dec_dst  = rd;
               dec_tnew = 2'd1;
            end else if (shamt_zero && funct == FN_JR) begin
               use_rs  = 1'b1;
               tuse_rs = 2'd0;
            end
         end
         OP_BEQ: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         OP_ORI: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            dec_dst  = rt;
            dec_tnew = 2'd1;
         end
         OP_LUI: begin
            dec_dst  = rt;
            dec_tnew = 2'd1;
         end
         OP_LW: begin
            use_rs   = 1'b1;
            tuse_rs  = 2'd1;
            dec_dst  = rt;
            dec_tnew = 2'd2;
         end
         OP_SW: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd2;
         end
         OP_JAL: begin
            dec_dst  = 5'd31;
            dec_tnew = 2'd0;
         end
         OP_J:    ;
         default: ;
      endcase
   end

   function automatic logic hit(input logic [NREG-1:0] dst, input logic [1:0] tnew,
                                input logic used, input logic [NREG-1:0] src,
                                input logic [1:0] tuse);
      return used && (dst != '0) && (dst == src) && (tnew > tuse);
   endfunction

   // W always holds tnew 0, so its terms can never fire; they fold away in synthesis.
   always_comb begin
      stall = hit(e_dst_q, e_tnew_q, use_rs, rs, tuse_rs)
            | hit(e_dst_q, e_tnew_q, use_rt, rt, tuse_rt)
            | hit(m_dst_q, m_tnew_q, use_rs, rs, tuse_rs)
            | hit(m_dst_q, m_tnew_q, use_rt, rt, tuse_rt)
            | hit(w_dst_q, w_tnew_q, use_rs, rs, tuse_rs)
            | hit(w_dst_q, w_tnew_q, use_rt, rt, tuse_rt);
   end

   assign en_PC = ~stall;
   assign en_D  = ~stall;
   assign clr_E = stall;

   always_comb begin
      e_dst_d  = stall ? '0 : dec_dst;
      e_tnew_d = stall ? 2'd0 : dec_tnew;
      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      w_dst_d  = m_dst_q;
      w_tnew_d = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dst_q  <= '0;
         e_tnew_q <= 2'd0;
         m_dst_q  <= '0;
         m_tnew_q <= 2'd0;
         w_dst_q  <= '0;
         w_tnew_q <= 2'd0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
      end
   end

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_d = stall ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; expected stall_cnt follows the STALL_CNT_EN build.
module tb_hazard_stall_unit;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      IR_D;
   logic             stall, en_PC, en_D, clr_E;
   logic [CNT_W-1:0] stall_cnt;

   int vectors = 0;
   int errors  = 0;

   localparam logic [31:0] NOP        = 32'h0000_0000;
   localparam logic [31:0] LW_1       = 32'h8C01_0000;
   localparam logic [31:0] LW_2       = 32'h8C02_0000;
   localparam logic [31:0] LW_0       = 32'h8C00_0000;
   localparam logic [31:0] ADDU_2_1_3 = 32'h0023_1021;
   localparam logic [31:0] BEQ_1_2    = 32'h1022_0001;
   localparam logic [31:0] ADDU_1_2_3 = 32'h0043_0821;
   localparam logic [31:0] JR_1       = 32'h0020_0008;
   localparam logic [31:0] ADDU_4_1_1 = 32'h0021_2021;
   localparam logic [31:0] SW_1_2     = 32'hAC41_0000;
   localparam logic [31:0] ADDU_2_0_0 = 32'h0000_1021;
   localparam logic [31:0] ADDU_3_1_2 = 32'h0022_1821;
   localparam logic [31:0] ORI_1      = 32'h3401_0005;
   localparam logic [31:0] LUI_1      = 32'h3C01_0001;

   hazard_stall_unit #(.NREG(5), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .IR_D      (IR_D),
      .stall     (stall),
      .en_PC     (en_PC),
      .en_D      (en_D),
      .clr_E     (clr_E),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef STALL_CNT_EN
      return CNT_W'(n);
`else
      return CNT_W'(0) & CNT_W'(n);
`endif
   endfunction

   // Present instr for one cycle, check the combinational outputs mid-cycle, then clock it in.
   task automatic step(input logic [31:0] instr, input logic exp_stall, input string tag);
      IR_D = instr;
      @(negedge clk);
      vectors++;
      assert (stall === exp_stall) else begin
         errors++;
         $error("FAIL %s stall observed=%b expected=%b", tag, stall, exp_stall);
      end
      assert ({en_PC, en_D, clr_E} === {~exp_stall, ~exp_stall, exp_stall}) else begin
         errors++;
         $error("FAIL %s en_PC/en_D/clr_E observed=%b%b%b expected=%b%b%b", tag,
                en_PC, en_D, clr_E, ~exp_stall, ~exp_stall, exp_stall);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input int n, input string tag);
      @(negedge clk);
      vectors++;
      assert (stall_cnt === exp_cnt(n)) else begin
         errors++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt(n));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      IR_D  = NOP;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      IR_D  = NOP;
      do_reset();
      step(NOP, 1'b0, "reset_idle");
      check_cnt(0, "reset_cnt");

      // lw $1 then addu $2,$1,$3: one stall, released with lw in M
      do_reset();
      step(LW_1,       1'b0, "lw_addu_lw");
      step(ADDU_2_1_3, 1'b1, "lw_addu_s1");
      step(ADDU_2_1_3, 1'b0, "lw_addu_rel");
      check_cnt(1, "lw_addu_cnt");

      // lw $1 then beq $1,$2: two stalls, bubbles keep E empty
      do_reset();
      step(LW_1,    1'b0, "lw_beq_lw");
      step(BEQ_1_2, 1'b1, "lw_beq_s1");
      step(BEQ_1_2, 1'b1, "lw_beq_s2");
      step(BEQ_1_2, 1'b0, "lw_beq_rel");
      step(NOP,     1'b0, "lw_beq_after");
      check_cnt(2, "lw_beq_cnt");

      // addu $1 then jr $1: one stall
      do_reset();
      step(ADDU_1_2_3, 1'b0, "addu_jr_addu");
      step(JR_1,       1'b1, "addu_jr_s1");
      step(JR_1,       1'b0, "addu_jr_rel");
      check_cnt(1, "addu_jr_cnt");

      // addu $1 then addu $4,$1,$1: forwarded, no stall
      do_reset();
      step(ADDU_1_2_3, 1'b0, "addu_addu_p");
      step(ADDU_4_1_1, 1'b0, "addu_addu_c");

      // lw $1 then addu $4,$1,$1: rs==rt still one stall
      do_reset();
      step(LW_1,       1'b0, "lw_rsrt_lw");
      step(ADDU_4_1_1, 1'b1, "lw_rsrt_s1");
      step(ADDU_4_1_1, 1'b0, "lw_rsrt_rel");

      // lw $1 then sw $1,0($2): store data Tuse 2, no stall
      do_reset();
      step(LW_1,   1'b0, "lw_sw_lw");
      step(SW_1_2, 1'b0, "lw_sw_sw");
      step(NOP,    1'b0, "lw_sw_after");

      // $0 destination never stalls
      do_reset();
      step(LW_0,       1'b0, "lw0_lw");
      step(ADDU_2_0_0, 1'b0, "lw0_addu");
      check_cnt(0, "no_stall_cnt");

      // lw $1, lw $2, addu $3,$1,$2: M entry satisfied, E entry stalls once
      do_reset();
      step(LW_1,       1'b0, "em_lw1");
      step(LW_2,       1'b0, "em_lw2");
      step(ADDU_3_1_2, 1'b1, "em_s1");
      step(ADDU_3_1_2, 1'b0, "em_rel");

      // ori $1 / lui $1 producers against Tuse-0 consumers
      do_reset();
      step(ORI_1, 1'b0, "ori_jr_ori");
      step(JR_1,  1'b1, "ori_jr_s1");
      step(JR_1,  1'b0, "ori_jr_rel");
      step(LUI_1,   1'b0, "lui_beq_lui");
      step(BEQ_1_2, 1'b1, "lui_beq_s1");
      step(BEQ_1_2, 1'b0, "lui_beq_rel");
      check_cnt(2, "ori_lui_cnt");

      // reset in the first cycle of the lw/beq stall clears the scoreboard
      do_reset();
      step(LW_1, 1'b0, "rst_mid_lw");
      reset = 1'b1;
      step(BEQ_1_2, 1'b1, "rst_mid_s1");
      reset = 1'b0;
      step(BEQ_1_2, 1'b0, "rst_mid_rel");
      check_cnt(0, "rst_mid_cnt");
      step(ADDU_2_1_3, 1'b0, "rst_mid_empty");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
